// File: rtl/scan_driver.sv
// scan_driver: four-digit multiplexed seven-segment scanner with a
// frame-synchronous load handshake. Each slot lasts DIV cycles, and all
// anodes stay dark for the first GAP cycles of every slot. A new value is
// parked in a shadow register and moves to the display register only at the
// end of a full four-slot scan, so a frame never mixes two values.
// Optional feature: define LZ_BLANK_EN to blank leading zeros; slot 0 always
// lights.
module scan_driver #(
  parameter int DIV = 1000,
  parameter int GAP = 2
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic [15:0] value,
  input  logic        load,
  output logic        ready,
  output logic [3:0]  digit,
  output logic [3:0]  anode,
  output logic        frame
);

  typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2, SLOT3} slot_t;

  localparam logic [15:0] TICK_LAST = 16'(DIV - 1);
  localparam logic [15:0] GAP_CYC   = 16'(GAP);

  logic [15:0] tick_cnt_reg, tick_cnt_next;
  slot_t       slot_reg, slot_next;
  logic [15:0] disp_reg, disp_next;
  logic [15:0] shadow_reg, shadow_next;
  logic        pending_reg, pending_next;
  logic        boundary;

  logic [3:0]  lit_next;
  logic [3:0]  slot_onehot;
  logic [3:0]  digit_next, anode_next;
  logic        frame_next;

  logic [3:0]  digit_reg, anode_reg;
  logic        frame_reg, ready_reg;

  // Next-state logic: tick counter, slot sequencing, display/shadow handshake.
  always_comb begin
    tick_cnt_next = tick_cnt_reg;
    slot_next     = slot_reg;
    disp_next     = disp_reg;
    shadow_next   = shadow_reg;
    pending_next  = pending_reg;
    boundary      = (slot_reg == SLOT3) && (tick_cnt_reg == TICK_LAST);

    if (tick_cnt_reg == TICK_LAST) begin
      tick_cnt_next = 16'd0;
      case (slot_reg)
        SLOT0:   slot_next = SLOT1;
        SLOT1:   slot_next = SLOT2;
        SLOT2:   slot_next = SLOT3;
        default: slot_next = SLOT0;
      endcase
    end else begin
      tick_cnt_next = tick_cnt_reg + 16'd1;
    end

    // The boundary transfer uses the old shadow, so a load taken in the same
    // cycle waits one more frame.
    if (boundary && pending_reg) begin
      disp_next    = shadow_reg;
      pending_next = 1'b0;
    end

    // ready is ~pending_reg, so acceptance never collides with the transfer.
    if (load && !pending_reg) begin
      shadow_next  = value;
      pending_next = 1'b1;
    end
  end

  // Per-slot light enable; slot 0 always lights.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi = gi + 1) begin : g_lit
      if (gi == 0) begin : g_first
        assign lit_next[gi] = 1'b1;
      end else begin : g_upper
`ifdef LZ_BLANK_EN
        assign lit_next[gi] = |disp_next[15:4*gi];
`else
        assign lit_next[gi] = 1'b1;
`endif
      end
    end
  endgenerate

  // Output values for the coming cycle, decoded from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    digit_next  = 4'h0;
    slot_onehot = 4'b0001;
    case (slot_next)
      SLOT0: begin digit_next = disp_next[3:0];   slot_onehot = 4'b0001; end
      SLOT1: begin digit_next = disp_next[7:4];   slot_onehot = 4'b0010; end
      SLOT2: begin digit_next = disp_next[11:8];  slot_onehot = 4'b0100; end
      default: begin digit_next = disp_next[15:12]; slot_onehot = 4'b1000; end
    endcase
    if (tick_cnt_next < GAP_CYC) begin
      anode_next = 4'b1111;
    end else begin
      anode_next = ~(slot_onehot & lit_next);
    end
    frame_next = (slot_next == SLOT3) && (tick_cnt_next == TICK_LAST);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      tick_cnt_reg <= 16'd0;
      slot_reg     <= SLOT0;
      disp_reg     <= 16'd0;
      shadow_reg   <= 16'd0;
      pending_reg  <= 1'b0;
      digit_reg    <= 4'h0;
      anode_reg    <= 4'b1111;
      frame_reg    <= 1'b0;
      ready_reg    <= 1'b1;
    end else begin
      tick_cnt_reg <= tick_cnt_next;
      slot_reg     <= slot_next;
      disp_reg     <= disp_next;
      shadow_reg   <= shadow_next;
      pending_reg  <= pending_next;
      digit_reg    <= digit_next;
      anode_reg    <= anode_next;
      frame_reg    <= frame_next;
      ready_reg    <= ~pending_next;
    end
  end

  assign digit = digit_reg;
  assign anode = anode_reg;
  assign frame = frame_reg;
  assign ready = ready_reg;

endmodule

// File: tb/tb_scan_driver.sv
// Bench for scan_driver with DIV=8, GAP=2. A cycle-count model (position in
// the 32-cycle frame) predicts every output each cycle; directed literal
// checks pin the model, then randomized loads and resets exercise it.
module tb_scan_driver;

  localparam int DIV   = 8;
  localparam int GAP   = 2;
  localparam int FRAME = 4 * DIV;

  logic        clock = 1'b0;
  logic        n_reset;
  logic [15:0] value;
  logic        load;
  logic        ready;
  logic [3:0]  digit;
  logic [3:0]  anode;
  logic        frame;

  int checks = 0;
  int errors = 0;

  scan_driver #(.DIV(DIV), .GAP(GAP)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .value   (value),
    .load    (load),
    .ready   (ready),
    .digit   (digit),
    .anode   (anode),
    .frame   (frame)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles since reset, display, shadow, pending.
  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  logic        m_pending;

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      m_t       <= 0;
      m_disp    <= 16'h0;
      m_shadow  <= 16'h0;
      m_pending <= 1'b0;
    end else begin
      if ((m_t % FRAME) == FRAME - 1 && m_pending) begin
        m_disp    <= m_shadow;
        m_pending <= 1'b0;
      end
      if (load && !m_pending) begin
        m_shadow  <= value;
        m_pending <= 1'b1;
        $display("load accepted value=%h at cycle %0d", value, m_t);
      end
      m_t <= m_t + 1;
    end
  end

  // Compare process: every cycle, outputs against the model.
  int          e_pos, e_slot, e_tick;
  logic [15:0] e_sh;
  logic [3:0]  e_digit, e_anode, e_onehot;
  logic        e_lit, e_frame;

  always @(negedge clock) begin
    e_pos  = m_t % FRAME;
    e_slot = e_pos / DIV;
    e_tick = e_pos % DIV;
    e_sh   = m_disp >> (4 * e_slot);
    e_digit = e_sh[3:0];
`ifdef LZ_BLANK_EN
    e_lit = (e_slot == 0) || (e_sh != 16'h0);
`else
    e_lit = 1'b1;
`endif
    e_onehot = 4'b0001 << e_slot;
    e_anode  = (e_tick < GAP || !e_lit) ? 4'b1111 : ~e_onehot;
    e_frame  = (e_pos == FRAME - 1);
    chk("model_digit", {12'h0, digit}, {12'h0, e_digit});
    chk("model_anode", {12'h0, anode}, {12'h0, e_anode});
    chk("model_frame", {15'h0, frame}, {15'h0, e_frame});
    chk("model_ready", {15'h0, ready}, {15'h0, !m_pending});
  end

  int cyc;

  task automatic step();
    @(negedge clock);
    cyc = cyc + 1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    n_reset = 1'b0;
    load    = 1'b0;
    value   = 16'h0;
    cyc     = 0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_anode", {12'h0, anode}, 16'h000F);
    chk("rst_digit", {12'h0, digit}, 16'h0000);
    chk("rst_ready", {15'h0, ready}, 16'h0001);
    chk("rst_frame", {15'h0, frame}, 16'h0000);
    @(negedge clock);
    n_reset = 1'b1;
    cyc = 0;
    chk("first_anode", {12'h0, anode}, 16'h000F);

    goto(2);
    chk("slot0_lit", {12'h0, anode}, 16'h000E);
    goto(8);
    chk("slot1_gap", {12'h0, anode}, 16'h000F);
    goto(10);
`ifdef LZ_BLANK_EN
    chk("slot1_lit", {12'h0, anode}, 16'h000F);
`else
    chk("slot1_lit", {12'h0, anode}, 16'h000D);
`endif
    goto(31);
    chk("frame_pulse", {15'h0, frame}, 16'h0001);
    goto(32);
    chk("frame_low", {15'h0, frame}, 16'h0000);

    // Mid-frame load of 12AF, then an ignored 5555.
    goto(40);
    value = 16'h12AF; load = 1'b1;
    goto(41);
    load = 1'b0;
    chk("ready_low", {15'h0, ready}, 16'h0000);
    goto(45);
    value = 16'h5555; load = 1'b1;
    goto(46);
    load = 1'b0;
    goto(63);
    chk("old_digit", {12'h0, digit}, 16'h0000);
    goto(64);
    chk("ready_back", {15'h0, ready}, 16'h0001);
    goto(66);
    chk("d0_F", {12'h0, digit}, 16'h000F);
    chk("d0_anode", {12'h0, anode}, 16'h000E);
    goto(72);
    chk("d1_A", {12'h0, digit}, 16'h000A);
    goto(80);
    chk("d2_2", {12'h0, digit}, 16'h0002);
    goto(88);
    chk("d3_1", {12'h0, digit}, 16'h0001);
    goto(96);
    chk("ignored_5555", {12'h0, digit}, 16'h000F);

    // Load in the frame-boundary cycle waits a full frame.
    goto(127);
    value = 16'h0042; load = 1'b1;
    goto(128);
    load = 1'b0;
    chk("bnd_hold", {12'h0, digit}, 16'h000F);
    chk("bnd_pending", {15'h0, ready}, 16'h0000);
    goto(159);
    chk("bnd_still_old", {12'h0, digit}, 16'h0001);
    goto(160);
    chk("bnd_new_d0", {12'h0, digit}, 16'h0002);
    goto(168);
    chk("bnd_new_d1", {12'h0, digit}, 16'h0004);

    // Reset during slot 2 with a pending load.
    goto(170);
    value = 16'hABCD; load = 1'b1;
    goto(171);
    load = 1'b0;
    goto(178);
    chk("d2_zero", {12'h0, digit}, 16'h0000);
`ifdef LZ_BLANK_EN
    chk("d2_anode", {12'h0, anode}, 16'h000F);
`else
    chk("d2_anode", {12'h0, anode}, 16'h000B);
`endif
    goto(180);
    #1 n_reset = 1'b0;
    #1;
    chk("mid_rst_anode", {12'h0, anode}, 16'h000F);
    chk("mid_rst_ready", {15'h0, ready}, 16'h0001);
    chk("mid_rst_digit", {12'h0, digit}, 16'h0000);
    repeat (2) @(negedge clock);
    n_reset = 1'b1;
    cyc = 0;
    goto(34);
    chk("post_rst_d0", {12'h0, digit}, 16'h0000);
    goto(60);
    chk("post_rst_d3", {12'h0, digit}, 16'h0000);
    chk("post_rst_ready", {15'h0, ready}, 16'h0001);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      load  = ($urandom_range(0, 3) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 699) == 0) begin
        #1 n_reset = 1'b0;
        @(negedge clock);
        #1 n_reset = 1'b1;
      end
    end
    load = 1'b0;
    repeat (70) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_driver.md
SCAN_DRIVER -- requirements
Module: scan_driver

Interface
REQ-001 Parameter DIV, default 1000, clock cycles per digit slot; legal range 4 to 2^16-1.
REQ-002 Parameter GAP, default 2, anti-ghosting cycles at the start of each slot; legal range 1 to DIV-2.
REQ-003 clock  input  1  the single system clock; all state changes on its rising edge.
REQ-004 n_reset  input  1  asynchronous, active-low reset.
REQ-005 value  input  16  four hex nibbles to display; nibble i = value[4i+3:4i]; slot 0 is least significant.
REQ-006 load  input  1  valid strobe for value.
REQ-007 ready  output  1  high when a new value can be accepted.
REQ-008 digit  output  4  nibble for the active slot; drives the seven-segment decoder's digit input.
REQ-009 anode  output  4  active-low digit enables; anode[i] low lights slot i.
REQ-010 frame  output  1  one-cycle pulse at the end of each full four-slot scan.

Function
REQ-011 tick_cnt SHALL count 0..DIV-1 and wrap to 0; on wrap, slot SHALL advance 0->1->2->3->0.
REQ-012 Scan SHALL be a 4-state machine, SLOT0..SLOT3, with transitions only on the tick_cnt wrap, in strict cyclic order.
REQ-013 digit SHALL equal nibble[slot] of the display register disp for the whole slot, including the gap.
REQ-014 anode SHALL be 4'b1111 while tick_cnt < GAP; otherwise only anode[slot] SHALL be low.
REQ-015 At most one anode bit SHALL be low in any cycle.
REQ-016 digit, anode, ready and frame SHALL be derived from registered state only; there is no combinational path from value or load.
REQ-017 A flag pending SHALL exist; ready SHALL equal ~pending.
REQ-018 When load and ready are both high at a clock edge, value SHALL be captured into shadow and pending SHALL be set.
REQ-019 load while ready is low SHALL be ignored; shadow is not modified.
REQ-020 Frame boundary = the cycle with slot==3 and tick_cnt==DIV-1; frame SHALL be high exactly in that cycle.
REQ-021 At the frame boundary edge, if pending, disp <= shadow and pending <= 0; otherwise disp SHALL hold.
REQ-022 A load accepted in the frame-boundary cycle SHALL NOT reach disp at that edge; it transfers at the next boundary.
REQ-023 disp SHALL change only at a frame boundary, so no frame ever shows a mix of old and new nibbles.
REQ-024 Acceptance-to-display latency SHALL be between 1 and 4*DIV cycles.

Reset
REQ-025 Asserting n_reset low SHALL immediately set tick_cnt=0, slot=SLOT0, disp=0, shadow=0 and pending=0.
REQ-026 During reset, outputs SHALL be: anode=4'b1111, digit=0, ready=1, frame=0.
REQ-027 Reset mid-scan or mid-handshake SHALL discard any pending value.
REQ-028 The first cycle after release SHALL be tick_cnt=0 of SLOT0.

Configuration
REQ-029 Macro LZ_BLANK_EN SHALL control leading-zero blanking.
REQ-030 With LZ_BLANK_EN defined: a slot i>0 whose nibble and all more-significant nibbles of disp are zero SHALL keep anode[i] high for its whole slot.
REQ-031 With LZ_BLANK_EN defined: slot 0 SHALL always light; scan timing and digit output SHALL be unchanged.
REQ-032 Without LZ_BLANK_EN: all four slots SHALL light per REQ-014.

Verification (DIV=8, GAP=2)
REQ-033 Reset release, value idle -> anode sequence per slot is 1111 x2 then 1110 x6, next slot 1111 x2 then 1101 x6, and so on; digit=0; frame pulses every 32 cycles.
REQ-034 load=1 with value=16'h12AF mid-frame -> ready low next cycle; disp=12AF after the next frame pulse; digit reads F, A, 2, 1 on slots 0-3; ready high again.
REQ-035 Second load of 16'h5555 while ready low, followed by a boundary -> disp keeps the first value; the 5555 load is ignored.
REQ-036 load of 16'h0042 in the frame-boundary cycle -> disp unchanged at that edge; disp=0042 one frame (32 cycles) later.
REQ-037 n_reset low during slot 2 with a pending load -> anode=1111 and ready=1 immediately; after release disp=0.
REQ-038 With LZ_BLANK_EN and disp=16'h0040 -> slots 0 and 1 light, slots 2 and 3 stay dark; disp=0 -> only slot 0 lights, showing 0.
